// File: rtl/arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding and block geometry defaults.
package arb_pkg;

   localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
   localparam int unsigned DEF_MEM_LATENCY     = 4;
   localparam int unsigned BLOCK_OFFSET_BITS   = $clog2(DEF_WORDS_PER_BLOCK) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_FILL_I = 3'd2;
   localparam logic [2:0] S_FILL_D = 3'd3;
   localparam logic [2:0] S_DONE_I = 3'd4;
   localparam logic [2:0] S_DONE_D = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_WRITE  = S_WRITE,
      ST_FILL_I = S_FILL_I,
      ST_FILL_D = S_FILL_D,
      ST_DONE_I = S_DONE_I,
      ST_DONE_D = S_DONE_D
   } arb_state_e;

endpackage

// File: rtl/fill_counter.sv
// Clear/enable up-counter with a terminal-count flag; used for fill issue and return tracking.
module fill_counter #(
   parameter int unsigned W    = 3,
   parameter int unsigned LAST = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign count_o = cnt_q;
   assign tc_o    = (cnt_q == W'(LAST));

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between I-cache fills, D-cache fills and D-side write-through,
// sequencing block fills with overlapped address issue.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
   parameter int unsigned MEM_LATENCY     = DEF_MEM_LATENCY,
   parameter int unsigned ADDR_W          = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_miss,
   input  logic [ADDR_W-1:0]                  i_miss_addr,
   input  logic                               d_miss,
   input  logic [ADDR_W-1:0]                  d_miss_addr,
   input  logic                               d_wr,
   input  logic [ADDR_W-1:0]                  d_wr_addr,
   input  logic [15:0]                        d_wr_data,
   output logic                               mem_en,
   output logic                               mem_wr,
   output logic [ADDR_W-1:0]                  mem_addr,
   output logic [15:0]                        mem_wdata,
   input  logic [15:0]                        mem_rdata,
   input  logic                               mem_data_valid,
   output logic [15:0]                        fill_data,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
   output logic                               i_fill_we,
   output logic                               d_fill_we,
   output logic                               i_fill_done,
   output logic                               d_fill_done,
   output logic                               d_wr_ack
);

   localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned OFF_W = IDX_W + 1;
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << OFF_W) - 1);

   // Parameter sanity: memory must have a nonzero latency and blocks are a power of two.
   if (MEM_LATENCY == 0 || WORDS_PER_BLOCK < 2 ||
       (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_param
      $error("mem_arbiter: unsupported WORDS_PER_BLOCK/MEM_LATENCY");
   end

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;

   logic              in_fill;
   logic              issue_en;
   logic              ret_en;
   logic              cnt_clr;
   logic [CNT_W-1:0]  issue_cnt;
   logic              issue_tc;
   logic [IDX_W-1:0]  ret_cnt;
   logic              ret_tc;

   assign in_fill  = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);
   assign issue_en = in_fill && !issue_tc;
   assign ret_en   = in_fill && mem_data_valid;
   assign cnt_clr  = (state_q == ST_DONE_I) || (state_q == ST_DONE_D);

   // Issue counter runs one past the last word so its terminal count marks issue complete.
   fill_counter #(
      .W    (CNT_W),
      .LAST (WORDS_PER_BLOCK)
   ) u_issue_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cnt_clr),
      .en_i    (issue_en),
      .count_o (issue_cnt),
      .tc_o    (issue_tc)
   );

   fill_counter #(
      .W    (IDX_W),
      .LAST (WORDS_PER_BLOCK - 1)
   ) u_ret_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cnt_clr),
      .en_i    (ret_en),
      .count_o (ret_cnt),
      .tc_o    (ret_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
      end
   end

   // Fixed-priority grant in IDLE; block base is captured on the grant.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      case (state_q)
         ST_IDLE: begin
            if (d_wr) begin
               state_d = ST_WRITE;
            end else if (d_miss) begin
               state_d = ST_FILL_D;
               base_d  = d_miss_addr & BLOCK_MASK;
            end else if (i_miss) begin
               state_d = ST_FILL_I;
               base_d  = i_miss_addr & BLOCK_MASK;
            end
         end
         ST_WRITE:  state_d = ST_IDLE;
         ST_FILL_I: if (mem_data_valid && ret_tc) state_d = ST_DONE_I;
         ST_FILL_D: if (mem_data_valid && ret_tc) state_d = ST_DONE_D;
         ST_DONE_I: state_d = ST_IDLE;
         ST_DONE_D: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output decode from registered state and counters; offset never carries past the block.
   always_comb begin
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_data   = '0;
      fill_word   = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      d_wr_ack    = 1'b0;
      case (state_q)
         ST_WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_ack  = 1'b1;
         end
         ST_FILL_I, ST_FILL_D: begin
            mem_en    = issue_en;
            mem_addr  = issue_en ? (base_q | (ADDR_W'(issue_cnt) << 1)) : '0;
            fill_data = mem_rdata;
            fill_word = ret_cnt;
            i_fill_we = (state_q == ST_FILL_I) && mem_data_valid;
            d_fill_we = (state_q == ST_FILL_D) && mem_data_valid;
         end
         ST_DONE_I: i_fill_done = 1'b1;
         ST_DONE_D: d_fill_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency pipelined memory model.
module tb_mem_arbiter;

   localparam int unsigned LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_miss, d_miss, d_wr;
   logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_data_valid;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack;

   logic             stray;
   logic [LAT-1:0]   pv;
   logic [15:0]      pa [LAT];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4), .ADDR_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_miss         (i_miss),
      .i_miss_addr    (i_miss_addr),
      .d_miss         (d_miss),
      .d_miss_addr    (d_miss_addr),
      .d_wr           (d_wr),
      .d_wr_addr      (d_wr_addr),
      .d_wr_data      (d_wr_data),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_data_valid (mem_data_valid),
      .fill_data      (fill_data),
      .fill_word      (fill_word),
      .i_fill_we      (i_fill_we),
      .d_fill_we      (d_fill_we),
      .i_fill_done    (i_fill_done),
      .d_fill_done    (d_fill_done),
      .d_wr_ack       (d_wr_ack)
   );

   // Memory model: a read accepted in cycle k returns in cycle k+LAT with data addr^A5A5.
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
   end

   assign mem_data_valid = pv[LAT-1] | stray;
   assign mem_rdata      = pv[LAT-1] ? (pa[LAT-1] ^ 16'hA5A5) : (stray ? 16'hDEAD : 16'h0000);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      check({tag, " mem_en"},      32'(mem_en),      32'd0);
      check({tag, " mem_wr"},      32'(mem_wr),      32'd0);
      check({tag, " mem_addr"},    32'(mem_addr),    32'd0);
      check({tag, " mem_wdata"},   32'(mem_wdata),   32'd0);
      check({tag, " fill_data"},   32'(fill_data),   32'd0);
      check({tag, " fill_word"},   32'(fill_word),   32'd0);
      check({tag, " i_fill_we"},   32'(i_fill_we),   32'd0);
      check({tag, " d_fill_we"},   32'(d_fill_we),   32'd0);
      check({tag, " i_fill_done"}, 32'(i_fill_done), 32'd0);
      check({tag, " d_fill_done"}, 32'(d_fill_done), 32'd0);
      check({tag, " d_wr_ack"},    32'(d_wr_ack),    32'd0);
   endtask

   // Called with the request visible in the current (cycle 0) IDLE; checks cycles 0..13,
   // then drops the miss at the DONE cycle.
   task automatic chk_fill(input bit side_d, input logic [15:0] base);
      logic        exp_en, exp_we;
      logic [15:0] exp_addr;
      string       s;
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         s        = $sformatf("%s@%04h c%0d", side_d ? "D" : "I", base, c);
         exp_en   = (c >= 1) && (c <= 8);
         exp_we   = (c >= 5) && (c <= 12);
         exp_addr = exp_en ? 16'(base + 16'(2 * (c - 1))) : 16'h0000;
         check({s, " mem_en"},    32'(mem_en),    32'(exp_en));
         check({s, " mem_addr"},  32'(mem_addr),  32'(exp_addr));
         check({s, " mem_wr"},    32'(mem_wr),    32'd0);
         check({s, " mem_wdata"}, 32'(mem_wdata), 32'd0);
         check({s, " d_wr_ack"},  32'(d_wr_ack),  32'd0);
         check({s, " own_we"},    32'(side_d ? d_fill_we : i_fill_we), 32'(exp_we));
         check({s, " other_we"},  32'(side_d ? i_fill_we : d_fill_we), 32'd0);
         check({s, " own_done"},  32'(side_d ? d_fill_done : i_fill_done), 32'(c == 13));
         check({s, " other_done"}, 32'(side_d ? i_fill_done : d_fill_done), 32'd0);
         if (exp_we) begin
            check({s, " fill_word"}, 32'(fill_word), 32'(c - 5));
            check({s, " fill_data"}, 32'(fill_data),
                  32'(16'(base + 16'(2 * (c - 5))) ^ 16'hA5A5));
         end
      end
      if (side_d) d_miss = 1'b0;
      else        i_miss = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0; stray = 1'b0;
      i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Stray valid in IDLE must be ignored.
      @(posedge clk); #1 stray = 1'b1;
      @(negedge clk);
      chk_all_zero("idle_strobe");
      @(posedge clk); #1 stray = 1'b0;
      @(negedge clk);
      chk_all_zero("idle_after_strobe");

      // Lone I miss.
      @(posedge clk); #1 i_miss = 1'b1; i_miss_addr = 16'h1234;
      chk_fill(1'b0, 16'h1230);

      // I and D together: D first, I granted right after DONE.
      @(posedge clk); #1
      i_miss = 1'b1; i_miss_addr = 16'h0040;
      d_miss = 1'b1; d_miss_addr = 16'h2008;
      chk_fill(1'b1, 16'h2000);
      chk_fill(1'b0, 16'h0040);

      // Write-through beats a simultaneous I miss.
      @(posedge clk); #1
      d_wr = 1'b1; d_wr_addr = 16'h0102; d_wr_data = 16'hBEEF;
      i_miss = 1'b1; i_miss_addr = 16'h0456;
      @(negedge clk);
      check("wr c0 mem_en", 32'(mem_en),   32'd0);
      check("wr c0 ack",    32'(d_wr_ack), 32'd0);
      @(negedge clk);
      check("wr c1 mem_en",    32'(mem_en),    32'd1);
      check("wr c1 mem_wr",    32'(mem_wr),    32'd1);
      check("wr c1 mem_addr",  32'(mem_addr),  32'h0102);
      check("wr c1 mem_wdata", 32'(mem_wdata), 32'hBEEF);
      check("wr c1 ack",       32'(d_wr_ack),  32'd1);
      d_wr = 1'b0; d_wr_addr = '0; d_wr_data = '0;
      chk_fill(1'b0, 16'h0450);

      // Top-of-memory block stays inside the block.
      @(posedge clk); #1 d_miss = 1'b1; d_miss_addr = 16'hFFF6;
      chk_fill(1'b1, 16'hFFF0);

      // Reset mid-fill, stray responses afterwards, then a clean D fill.
      @(posedge clk); #1 i_miss = 1'b1; i_miss_addr = 16'h1234;
      repeat (7) @(negedge clk);
      check("mid mem_en",   32'(mem_en),   32'd1);
      check("mid mem_addr", 32'(mem_addr), 32'h123A);
      check("mid i_we",     32'(i_fill_we), 32'd1);
      rst_n = 1'b0; i_miss = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d i_we", c),  32'(i_fill_we), 32'd0);
         check($sformatf("post_rst%0d word", c),  32'(fill_word), 32'd0);
         check($sformatf("post_rst%0d mem_en", c), 32'(mem_en),  32'd0);
      end
      @(posedge clk); #1 stray = 1'b1;
      @(negedge clk);
      chk_all_zero("post_rst_strobe");
      @(posedge clk); #1 stray = 1'b0; d_miss = 1'b1; d_miss_addr = 16'h3456;
      chk_fill(1'b1, 16'h3450);

      @(negedge clk);
      chk_all_zero("final_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle memory arbiter for the cached pipeline. It shares the single unified main memory between the instruction-cache miss path (fetch stage) and the data-cache miss and write-through path (memory stage). It sequences eight-word block fills with overlapped address issue and returns each fill word to the owning cache. The pipeline stalls on the raw miss signals until the matching fill-done pulse.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8, words per cache block (power of two); word index width is log2 of this.
- MEM_LATENCY, 4, cycles from an accepted read issue to its mem_data_valid.
- ADDR_W, 16, byte address width; words are 16 bits, word addresses step by 2.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache miss; level, held until i_fill_done
- i_miss_addr  in  16  I-side miss byte address
- d_miss  in  1  D-cache miss; level, held until d_fill_done
- d_miss_addr  in  16  D-side miss byte address
- d_wr  in  1  D-side write-through request; level, held until d_wr_ack
- d_wr_addr  in  16  write byte address
- d_wr_data  in  16  write data
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  write (1) or read (0)
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  mem_rdata valid this cycle
- fill_data  out  16  word being filled (mem_rdata passthrough)
- fill_word  out  3  word index within block
- i_fill_we  out  1  write fill_data into the I-cache block
- d_fill_we  out  1  write fill_data into the D-cache block
- i_fill_done  out  1  one-cycle pulse; I block complete
- d_fill_done  out  1  one-cycle pulse; D block complete
- d_wr_ack  out  1  one-cycle pulse; write issued to memory

## Operation
- States:
  - IDLE
  - WRITE: one cycle
  - FILL_I, FILL_D: block fill for the named side
  - DONE_I, DONE_D: one cycle each
- Arbitration, sampled only in IDLE, fixed priority: d_wr, then d_miss, then i_miss. No request latches the block until it is served.
- Block base is the miss address with the low log2(WORDS_PER_BLOCK)+1 bits cleared. The base is latched on leaving IDLE, so later address changes are ignored.
- WRITE:
  - mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data.
  - d_wr_ack=1 in the same cycle.
  - Next state is IDLE.
- FILL:
  - An issue counter drives mem_en=1, mem_wr=0, mem_addr = base + 2×issue_cnt for WORDS_PER_BLOCK consecutive cycles, then deasserts mem_en.
  - A separate return counter increments on each mem_data_valid. fill_word equals the return counter, and the side's fill_we equals mem_data_valid.
  - After the last return, the next state is DONE.
- DONE:
  - Pulse the matching fill_done.
  - Both counters clear; next state is IDLE.
  - The cache updates tag/valid on this edge, so the miss is low by the following IDLE.
- Address arithmetic is 16-bit. Base plus offset never carries out of the block, e.g. base 0xFFF0 issues 0xFFF0 through 0xFFFE.
- mem_data_valid in IDLE, WRITE or DONE is ignored: no fill_we and no counter change.
- mem_wdata is 0 whenever mem_wr=0.

## Timing
- Reset (asynchronous, any state): state=IDLE, all counters and latched base cleared, every output 0.
  - Memory responses still in flight are discarded under the IDLE rule.
  - A request pending at reset release is served normally.
- Write latency:
  - Request seen in IDLE at cycle 0.
  - WRITE and d_wr_ack at cycle 1.
  - IDLE again at cycle 2.
- Fill latency (WORDS_PER_BLOCK=8, MEM_LATENCY=4):
  - Request seen at cycle 0.
  - Issues at cycles 1–8.
  - fill_we at cycles 5–12, fill_word 0–7.
  - DONE and fill_done at cycle 13.
  - IDLE at cycle 14.
  - Total miss penalty 14 cycles.
- Back-to-back: a second requester pending at DONE is granted in the IDLE cycle that follows, with no extra bubble.
- Simultaneous d_wr, d_miss and i_miss: write first, then D fill, then I fill. The I side waits 2 + 14 cycles before its own 14.

## Structure
- Shared package arb_pkg holds:
  - state encoding localparams (IDLE, WRITE, FILL_I, FILL_D, DONE_I, DONE_D)
  - BLOCK_OFFSET_BITS
  - default WORDS_PER_BLOCK and MEM_LATENCY
- Single module with one state register, issue counter, return counter and latched base/side.
- One natural sub-module, fill_counter: a parametrised clear/enable up-counter with a terminal-count flag. It is instantiated twice, for issue and return.

## Test plan
- i_miss at 0x1234, others idle:
  - mem_addr 0x1230, 0x1232 … 0x123E at cycles 1–8.
  - i_fill_we cycles 5–12 with fill_word 0–7.
  - i_fill_done cycle 13; d_fill_we never asserts.
- i_miss and d_miss asserted together at 0x0040 and 0x2008:
  - D fill of 0x2000–0x200E first, d_fill_done at cycle 13.
  - I issues begin at cycle 15.
- d_wr (0x0102, 0xBEEF) raised together with i_miss:
  - mem_wr=1, mem_addr=0x0102, mem_wdata=0xBEEF and d_wr_ack at cycle 1.
  - I fill issues begin at cycle 3.
- d_miss at 0xFFF6 → addresses 0xFFF0 through 0xFFFE with no wrap to 0x0000.
- rst_n pulsed low at cycle 6 of an I fill:
  - All outputs 0 immediately.
  - Subsequent stray mem_data_valid pulses produce no fill_we.
  - A new d_miss after release completes with the standard 14-cycle timing.
- mem_data_valid strobed while IDLE → no fill_we or fill_done, and the counters stay at 0.
